// File: rtl/impact_sram_sequencer.sv
// Access sequencer for the SRAM/ReRAM test array: turns a valid/ready request into
// precharge -> wordline -> sense/write phases with programmable phase lengths.
`timescale 1ns/1ps
module impact_sram_sequencer #(
  parameter  int DATA_W    = 8,
  parameter  int ADDR_W    = 6,
  parameter  int NUM_BANKS = 4,
  parameter  int PRE_CYC   = 2,
  parameter  int WL_CYC    = 2,
  localparam int BYTES     = DATA_W / 8,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BANK_W-1:0] req_bank,
  input  logic [BYTES-1:0]  req_byte_en,
  input  logic              req_trunc,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [NUM_BANKS-1:0] arr_bank_sel,
  output logic [ADDR_W-1:0] arr_addr,
  output logic              arr_precharge,
  output logic              arr_wl_en,
  output logic              arr_read_en,
  output logic              arr_write_en,
  output logic [BYTES-1:0]  arr_din_en,
  output logic [DATA_W-1:0] arr_wdata,
  input  logic [DATA_W-1:0] arr_rdata
);

  localparam int MAX_CYC    = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
  localparam int CNT_W      = $clog2(MAX_CYC + 1);
  localparam int BANK_SLOTS = 1 << BANK_W;
  localparam logic [DATA_W-1:0] LO_MASK = {{(DATA_W/2){1'b0}}, {(DATA_W/2){1'b1}}};

  typedef enum logic [1:0] {IDLE, PRE, ACCESS, RESP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_load;
  logic               we_r, trunc_r;
  logic [BANK_W-1:0]  bank_r, bank_idx;
  logic [BYTES-1:0]   be_r;
  logic [BANK_SLOTS-1:0] bank_ok;
  logic               accept, acc_err, acc_noop;

  // Bank indices beyond NUM_BANKS are representable when NUM_BANKS is not a power of two.
  always_comb begin
    bank_ok = '0;
    for (int unsigned i = 0; i < BANK_SLOTS; i++)
      bank_ok[i] = (i < unsigned'(NUM_BANKS));
  end

  assign accept   = (state == IDLE) && req_valid;
  assign acc_err  = !bank_ok[req_bank];
  assign acc_noop = req_we && (req_byte_en == '0);
  assign bank_idx = accept ? req_bank : bank_r;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = (acc_err || acc_noop) ? RESP : PRE;
      PRE:     if (cnt == '0) state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_load = '0;
    unique case (state_nxt)
      PRE:     cnt_load = CNT_W'(PRE_CYC - 1);
      ACCESS:  cnt_load = CNT_W'(WL_CYC - 1);
      default: cnt_load = '0;
    endcase
  end

  // Outputs are registered from the next state so strobes align with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      we_r          <= 1'b0;
      trunc_r       <= 1'b0;
      bank_r        <= '0;
      be_r          <= '0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= '0;
      arr_bank_sel  <= '0;
      arr_addr      <= '0;
      arr_precharge <= 1'b0;
      arr_wl_en     <= 1'b0;
      arr_read_en   <= 1'b0;
      arr_write_en  <= 1'b0;
      arr_din_en    <= '0;
      arr_wdata     <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= cnt_load;
      else if (cnt != '0)
        cnt <= cnt - 1'b1;

      if (accept) begin
        we_r      <= req_we;
        trunc_r   <= req_trunc;
        bank_r    <= req_bank;
        be_r      <= req_byte_en;
        arr_addr  <= req_addr;
        arr_wdata <= req_wdata;
      end

      req_ready     <= (state_nxt == IDLE);
      arr_precharge <= (state_nxt == PRE);
      arr_wl_en     <= (state_nxt == ACCESS);
      arr_read_en   <= (state_nxt == ACCESS) && !we_r;
      arr_write_en  <= (state_nxt == ACCESS) && we_r;
      arr_din_en    <= ((state_nxt == ACCESS) && we_r) ? be_r : '0;
      arr_bank_sel  <= ((state_nxt == PRE) || (state_nxt == ACCESS))
                       ? (NUM_BANKS'(1) << bank_idx) : '0;

      rsp_valid <= (state_nxt == RESP);
      rsp_err   <= accept && acc_err;
      if ((state == ACCESS) && (state_nxt == RESP) && !we_r)
        rsp_rdata <= trunc_r ? (arr_rdata & LO_MASK) : arr_rdata;
      else
        rsp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_impact_sram_sequencer.sv
// Bench for impact_sram_sequencer: a default 8-bit/4-bank instance with a behavioural
// array model, and a 16-bit/3-bank instance with PRE_CYC=3, WL_CYC=1.
`timescale 1ns/1ps
module tb_impact_sram_sequencer;

  localparam int A_P = 2;
  localparam int A_W = 2;
  localparam int B_P = 3;
  localparam int B_W = 1;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  logic a_rst = 1'b1;
  logic b_rst = 1'b1;
  always #5 clk = ~clk;

  // instance A: DATA_W=8, NUM_BANKS=4
  logic       a_req_valid = 1'b0, a_req_ready, a_req_we = 1'b0, a_req_trunc = 1'b0;
  logic [5:0] a_req_addr = '0;
  logic [1:0] a_req_bank = '0;
  logic [0:0] a_req_byte_en = '0;
  logic [7:0] a_req_wdata = '0;
  logic       a_rsp_valid, a_rsp_err;
  logic [7:0] a_rsp_rdata;
  logic [3:0] a_arr_bank_sel;
  logic [5:0] a_arr_addr;
  logic       a_arr_precharge, a_arr_wl_en, a_arr_read_en, a_arr_write_en;
  logic [0:0] a_arr_din_en;
  logic [7:0] a_arr_wdata, a_arr_rdata;

  // instance B: DATA_W=16, NUM_BANKS=3
  logic        b_req_valid = 1'b0, b_req_ready, b_req_we = 1'b0, b_req_trunc = 1'b0;
  logic [5:0]  b_req_addr = '0;
  logic [1:0]  b_req_bank = '0;
  logic [1:0]  b_req_byte_en = '0;
  logic [15:0] b_req_wdata = '0;
  logic        b_rsp_valid, b_rsp_err;
  logic [15:0] b_rsp_rdata;
  logic [2:0]  b_arr_bank_sel;
  logic [5:0]  b_arr_addr;
  logic        b_arr_precharge, b_arr_wl_en, b_arr_read_en, b_arr_write_en;
  logic [1:0]  b_arr_din_en;
  logic [15:0] b_arr_wdata, b_arr_rdata;

  impact_sram_sequencer #(.DATA_W(8), .ADDR_W(6), .NUM_BANKS(4), .PRE_CYC(A_P), .WL_CYC(A_W)) dut_a (
    .clk(clk), .rst(a_rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_bank(a_req_bank), .req_byte_en(a_req_byte_en),
    .req_trunc(a_req_trunc), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err), .rsp_rdata(a_rsp_rdata),
    .arr_bank_sel(a_arr_bank_sel), .arr_addr(a_arr_addr), .arr_precharge(a_arr_precharge),
    .arr_wl_en(a_arr_wl_en), .arr_read_en(a_arr_read_en), .arr_write_en(a_arr_write_en),
    .arr_din_en(a_arr_din_en), .arr_wdata(a_arr_wdata), .arr_rdata(a_arr_rdata)
  );

  impact_sram_sequencer #(.DATA_W(16), .ADDR_W(6), .NUM_BANKS(3), .PRE_CYC(B_P), .WL_CYC(B_W)) dut_b (
    .clk(clk), .rst(b_rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_bank(b_req_bank), .req_byte_en(b_req_byte_en),
    .req_trunc(b_req_trunc), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rsp_rdata(b_rsp_rdata),
    .arr_bank_sel(b_arr_bank_sel), .arr_addr(b_arr_addr), .arr_precharge(b_arr_precharge),
    .arr_wl_en(b_arr_wl_en), .arr_read_en(b_arr_read_en), .arr_write_en(b_arr_write_en),
    .arr_din_en(b_arr_din_en), .arr_wdata(b_arr_wdata), .arr_rdata(b_arr_rdata)
  );

  // Array model for A: data is valid only in the last wordline cycle of a read,
  // the inverted word otherwise; writes land on each write-enabled edge.
  logic [7:0]  mem_a [4][64] = '{default: 8'h00};
  logic [7:0]  ref_a [4][64] = '{default: 8'h00};
  int unsigned rd_run = 0;
  int unsigned sel_a;

  always_comb begin
    sel_a = 0;
    for (int unsigned i = 0; i < 4; i++)
      if (a_arr_bank_sel[i]) sel_a = i;
  end

  assign a_arr_rdata = (a_arr_read_en && rd_run == A_W - 1) ? mem_a[sel_a][a_arr_addr]
                                                            : ~mem_a[sel_a][a_arr_addr];

  always @(posedge clk) begin
    rd_run <= a_arr_read_en ? rd_run + 1 : 0;
    if (a_arr_write_en && a_arr_din_en[0])
      mem_a[sel_a][a_arr_addr] <= a_arr_wdata;
  end

  assign b_arr_rdata = b_arr_read_en ? 16'hC3A5 : 16'h0BAD;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic txn_a(input logic we, input logic [5:0] addr, input logic [1:0] bank,
                       input logic be, input logic tr, input logic [7:0] wd, input string tag);
    logic [7:0]  exp_rd;
    logic [11:0] obs, exp_v;
    logic        noop, pre, wl;
    int unsigned last;
    noop   = we && !be;
    exp_rd = 8'h00;
    if (!we) exp_rd = tr ? (ref_a[bank][addr] & 8'h0F) : ref_a[bank][addr];
    else if (be) ref_a[bank][addr] = wd;
    last = noop ? 1 : A_P + A_W + 1;
    @(negedge clk);
    checks++;
    if (a_req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_idle: got %b want 1", tag, a_req_ready);
    end
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_bank = bank;
    a_req_byte_en = be; a_req_trunc = tr; a_req_wdata = wd;
    @(negedge clk);
    a_req_valid = 1'b0; a_req_we = 1'($urandom); a_req_addr = 6'($urandom);
    a_req_bank = 2'($urandom); a_req_wdata = 8'($urandom);
    for (int unsigned k = 1; k <= last + 1; k++) begin
      if (k > 1) @(negedge clk);
      pre = !noop && (k <= A_P);
      wl  = !noop && (k > A_P) && (k <= A_P + A_W);
      exp_v = {k > last, k == last, 1'b0, pre, wl, wl && !we, wl && we, wl && we && be,
               ((pre || wl) ? (4'(1) << bank) : 4'b0)};
      obs = {a_req_ready, a_rsp_valid, a_rsp_err, a_arr_precharge, a_arr_wl_en,
             a_arr_read_en, a_arr_write_en, a_arr_din_en, a_arr_bank_sel};
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL %s ctrl cycle %0d: got %b want %b", tag, k, obs, exp_v);
      end
      if (k == last) begin
        checks++;
        if (a_rsp_rdata !== exp_rd) begin
          errors++; $display("FAIL %s rdata: got %h want %h", tag, a_rsp_rdata, exp_rd);
        end
      end
      if (pre || wl) begin
        checks++;
        if (a_arr_addr !== addr) begin
          errors++; $display("FAIL %s addr cycle %0d: got %h want %h", tag, k, a_arr_addr, addr);
        end
      end
      if (wl && we) begin
        checks++;
        if (a_arr_wdata !== wd) begin
          errors++; $display("FAIL %s wdata cycle %0d: got %h want %h", tag, k, a_arr_wdata, wd);
        end
      end
    end
  endtask

  task automatic txn_b(input logic we, input logic [5:0] addr, input logic [1:0] bank,
                       input logic [1:0] be, input logic tr, input logic [15:0] wd, input string tag);
    logic [15:0] exp_rd;
    logic [11:0] obs, exp_v;
    logic        err, noop, pre, wl;
    int unsigned last;
    err    = (bank > 2'd2);
    noop   = !err && we && (be == 2'b00);
    last   = (err || noop) ? 1 : B_P + B_W + 1;
    exp_rd = (err || we) ? 16'h0000 : (tr ? 16'h00A5 : 16'hC3A5);
    @(negedge clk);
    checks++;
    if (b_req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_idle: got %b want 1", tag, b_req_ready);
    end
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_bank = bank;
    b_req_byte_en = be; b_req_trunc = tr; b_req_wdata = wd;
    @(negedge clk);
    b_req_valid = 1'b0; b_req_byte_en = 2'($urandom); b_req_wdata = 16'($urandom);
    for (int unsigned k = 1; k <= last + 1; k++) begin
      if (k > 1) @(negedge clk);
      pre = !err && !noop && (k <= B_P);
      wl  = !err && !noop && (k > B_P) && (k <= B_P + B_W);
      exp_v = {k > last, k == last, err && (k == last), pre, wl, wl && !we, wl && we,
               ((wl && we) ? be : 2'b00), ((pre || wl) ? (3'(1) << bank) : 3'b0)};
      obs = {b_req_ready, b_rsp_valid, b_rsp_err, b_arr_precharge, b_arr_wl_en,
             b_arr_read_en, b_arr_write_en, b_arr_din_en, b_arr_bank_sel};
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL %s ctrl cycle %0d: got %b want %b", tag, k, obs, exp_v);
      end
      if (k == last) begin
        checks++;
        if (b_rsp_rdata !== exp_rd) begin
          errors++; $display("FAIL %s rdata: got %h want %h", tag, b_rsp_rdata, exp_rd);
        end
      end
      if (wl && we) begin
        checks++;
        if (b_arr_wdata !== wd) begin
          errors++; $display("FAIL %s wdata: got %h want %h", tag, b_arr_wdata, wd);
        end
      end
    end
  endtask

  task automatic test_reset;
    logic [11:0] obs;
    #1;
    a_rst = 1'b0; b_rst = 1'b0;
    for (int unsigned n = 0; n < 2; n++) begin
      @(negedge clk);
      obs = {a_req_ready, a_rsp_valid, a_rsp_err, a_arr_precharge, a_arr_wl_en,
             a_arr_read_en, a_arr_write_en, a_arr_din_en, a_arr_bank_sel};
      checks++;
      if (obs !== 12'b1000_0000_0000 || a_rsp_rdata !== 8'h00 || a_arr_addr !== 6'h00 || a_arr_wdata !== 8'h00) begin
        errors++; $display("FAIL reset_a phase %0d: got %b/%h/%h/%h want 100000000000/00/00/00",
                           n, obs, a_rsp_rdata, a_arr_addr, a_arr_wdata);
      end
      obs = {b_req_ready, b_rsp_valid, b_rsp_err, b_arr_precharge, b_arr_wl_en,
             b_arr_read_en, b_arr_write_en, b_arr_din_en, b_arr_bank_sel};
      checks++;
      if (obs !== 12'b1000_0000_0000 || b_rsp_rdata !== 16'h0000 || b_arr_wdata !== 16'h0000) begin
        errors++; $display("FAIL reset_b phase %0d: got %b/%h/%h want 100000000000/0000/0000",
                           n, obs, b_rsp_rdata, b_arr_wdata);
      end
      a_rst = 1'b1; b_rst = 1'b1;
    end
  endtask

  task automatic test_write;
    txn_a(1'b1, 6'h15, 2'd1, 1'b1, 1'b0, 8'hA5, "write_b1");
  endtask

  task automatic test_read;
    txn_a(1'b0, 6'h15, 2'd1, 1'b0, 1'b0, 8'h00, "read_b1");
    txn_a(1'b0, 6'h15, 2'd1, 1'b0, 1'b1, 8'h00, "read_trunc");
    txn_a(1'b1, 6'h15, 2'd1, 1'b0, 1'b0, 8'h77, "noop_write_a");
    txn_a(1'b0, 6'h15, 2'd1, 1'b0, 1'b0, 8'h00, "read_after_noop");
  endtask

  task automatic test_back_to_back;
    logic [7:0]  e1, e2;
    int unsigned pulses;
    txn_a(1'b1, 6'h03, 2'd2, 1'b1, 1'b0, 8'($urandom), "b2b_prep1");
    txn_a(1'b1, 6'h04, 2'd2, 1'b1, 1'b0, 8'($urandom), "b2b_prep2");
    e1 = ref_a[2][3];
    e2 = ref_a[2][4];
    pulses = 0;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 6'h03; a_req_bank = 2'd2;
    a_req_byte_en = 1'b0; a_req_trunc = 1'b0;
    for (int unsigned k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) a_req_addr = 6'h04;
      checks++;
      if ((a_arr_precharge && a_arr_wl_en) !== 1'b0) begin
        errors++; $display("FAIL b2b_overlap cycle %0d: got pre=%b wl=%b want not both", k, a_arr_precharge, a_arr_wl_en);
      end
      if (a_rsp_valid === 1'b1) pulses++;
      if (k == 5 || k == 11) begin
        checks++;
        if ({a_rsp_valid, a_rsp_rdata} !== {1'b1, (k == 5) ? e1 : e2}) begin
          errors++; $display("FAIL b2b_rsp cycle %0d: got %b/%h want 1/%h", k, a_rsp_valid, a_rsp_rdata, (k == 5) ? e1 : e2);
        end
      end
      if (k == 6 || k == 7) begin
        checks++;
        if ({a_req_ready, a_arr_precharge} !== ((k == 6) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL b2b_accept cycle %0d: got ready/pre %b%b want %b", k, a_req_ready, a_arr_precharge, (k == 6) ? 2'b10 : 2'b01);
        end
        if (k == 7) a_req_valid = 1'b0;
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses);
    end
  endtask

  task automatic test_reset_abort;
    logic [11:0] obs;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 6'h07; a_req_bank = 2'd0;
    a_req_byte_en = 1'b1; a_req_trunc = 1'b0; a_req_wdata = 8'h5A;
    for (int unsigned k = 1; k <= 3; k++) begin
      @(negedge clk);
      a_req_valid = 1'b0;
    end
    checks++;
    if (a_arr_write_en !== 1'b1) begin
      errors++; $display("FAIL abort_pre write_en: got %b want 1", a_arr_write_en);
    end
    #1 a_rst = 1'b0;
    #1;
    obs = {a_req_ready, a_rsp_valid, a_rsp_err, a_arr_precharge, a_arr_wl_en,
           a_arr_read_en, a_arr_write_en, a_arr_din_en, a_arr_bank_sel};
    checks++;
    if (obs !== 12'b1000_0000_0000) begin
      errors++; $display("FAIL abort_async: got %b want 100000000000", obs);
    end
    @(negedge clk);
    a_rst = 1'b1;
    for (int unsigned k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({a_rsp_valid, a_req_ready, a_arr_precharge, a_arr_wl_en} !== 4'b0100) begin
        errors++; $display("FAIL abort_after cycle %0d: got %b%b%b%b want 0100", k, a_rsp_valid, a_req_ready, a_arr_precharge, a_arr_wl_en);
      end
    end
    txn_a(1'b0, 6'h07, 2'd0, 1'b0, 1'b0, 8'h00, "abort_read");
  endtask

  task automatic test_random;
    for (int unsigned n = 0; n < 40; n++)
      txn_a(1'($urandom), 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), "random");
  endtask

  task automatic test_wide_mask;
    txn_b(1'b1, 6'h09, 2'd2, 2'b10, 1'b0, 16'hBEEF, "wide_mask");
    txn_b(1'b1, 6'h09, 2'd0, 2'b11, 1'b0, 16'h1357, "wide_full");
    txn_b(1'b0, 6'h09, 2'd1, 2'b11, 1'b0, 16'h0000, "wide_read");
    txn_b(1'b0, 6'h09, 2'd1, 2'b00, 1'b1, 16'h0000, "wide_trunc");
  endtask

  task automatic test_noop_write;
    txn_b(1'b1, 6'h05, 2'd1, 2'b00, 1'b0, 16'h1234, "noop_write_b");
  endtask

  task automatic test_bank_err;
    txn_b(1'b0, 6'h03, 2'd3, 2'b11, 1'b0, 16'h0000, "bank_err_rd");
    txn_b(1'b1, 6'h03, 2'd3, 2'b11, 1'b0, 16'hFFFF, "bank_err_wr");
    txn_b(1'b0, 6'h03, 2'd2, 2'b00, 1'b0, 16'h0000, "bank_max_ok");
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_reset_abort;
    test_random;
    test_wide_mask;
    test_noop_write;
    test_bank_err;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/impact_sram_sequencer.md
# impact_sram_sequencer

Parametrised access sequencer for the custom SRAM/ReRAM test array. It replaces pin-level driving of PreCharge, WL_enable, ReadEnable, WriteEnable and Data_In_Enable with a single-request valid/ready interface. It generates the precharge → wordline → sense/write phase sequence with programmable phase lengths. It adds multi-byte words, per-byte write masking, read truncation, multi-bank select and out-of-range bank error reporting, and sits between the user-project I/O decode and the array macro.

## Interface
- DATA_W, 8: word width; multiple of 8; BYTES = DATA_W/8.
- ADDR_W, 6: row address width.
- NUM_BANKS, 4: number of selectable arrays, ≥1; BANK_W = max(1, clog2(NUM_BANKS)).
- PRE_CYC, 2: precharge phase length in cycles, ≥1.
- WL_CYC, 2: wordline/access phase length in cycles, ≥1.

- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  row address.
- req_bank  in  BANK_W  target bank index.
- req_byte_en  in  BYTES  write byte mask; ignored for reads.
- req_trunc  in  1  read truncation: zero upper half of returned word.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse, reads and writes.
- rsp_err  out  1  qualifies rsp_valid: bank index out of range.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- arr_bank_sel  out  NUM_BANKS  one-hot bank enable.
- arr_addr  out  ADDR_W  registered row address.
- arr_precharge  out  1  bitline precharge strobe.
- arr_wl_en  out  1  wordline enable.
- arr_read_en  out  1  sense enable.
- arr_write_en  out  1  write driver enable.
- arr_din_en  out  BYTES  per-byte data-in enable.
- arr_wdata  out  DATA_W  registered write data.
- arr_rdata  in  DATA_W  array sense output; valid during the last WL cycle.

## Operation
- States: IDLE, PRE, ACCESS, RESP.
- IDLE: req_ready=1; all arr_* strobes 0. On req_valid&&req_ready, register we/addr/bank/byte_en/trunc/wdata.
  - Bank ≥ NUM_BANKS: go to RESP with error set; no array strobe ever asserts.
  - Write with req_byte_en == 0: go to RESP directly (no-op, no error).
  - Otherwise go to PRE.
- PRE: arr_precharge=1, arr_bank_sel one-hot of bank, arr_addr held. Lasts PRE_CYC cycles, then ACCESS.
- ACCESS: arr_precharge=0, arr_wl_en=1, for WL_CYC cycles.
  - Read: arr_read_en=1, arr_write_en=0, arr_din_en=0.
  - Write: arr_write_en=1, arr_din_en=registered byte_en, arr_wdata driven.
  - On the final cycle, reads capture arr_rdata. If trunc, the captured bits [DATA_W-1:DATA_W/2] are forced to 0.
- RESP: all strobes 0, bank_sel 0. rsp_valid=1 for exactly one cycle with rsp_err/rsp_rdata. Next state IDLE.
- arr_precharge and arr_wl_en are never high in the same cycle; the registered outputs are decoded from state.
- The phase counter is clog2(max(PRE_CYC,WL_CYC)+1) bits, reloads on each state entry, and does not wrap.
- Request inputs are ignored outside IDLE. A request held during busy is accepted at the next IDLE cycle.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, arr_bank_sel=0, arr_addr=0, arr_wdata=0, all strobes 0.
- Assertion mid-sequence drops all strobes immediately, without waiting for a clock edge; no rsp_valid is issued for the aborted request.
- Edge 0 accepts the request.
  - Precharge is high for cycles 1..PRE_CYC.
  - Wordline is high for cycles PRE_CYC+1..PRE_CYC+WL_CYC.
  - rsp_valid is high in cycle PRE_CYC+WL_CYC+1.
- Normal-access latency from accept to rsp_valid is PRE_CYC+WL_CYC+1 cycles; defaults give 5.
- Error and no-op writes: rsp_valid in cycle 1 after accept.
- Throughput: one request per PRE_CYC+WL_CYC+2 cycles. req_ready is low from cycle 1 through the RESP cycle and returns high the cycle after RESP.

## Test plan
- Write bank 1, addr 0x15, wdata 0xA5, byte_en 1, defaults. Required: precharge high in cycles 1–2, wl_en+write_en high in cycles 3–4, din_en=1, bank_sel=0010, rsp_valid in cycle 5 with rsp_err=0.
- Read of the same location with model arr_rdata=0xA5 in the last WL cycle. Required: rsp_rdata=0xA5 in cycle 5. Repeat with trunc=1, DATA_W=8: required rsp_rdata=0x05.
- DATA_W=16, write with byte_en=2'b10, wdata 0xBEEF. Required: arr_din_en=2'b10 throughout ACCESS. With byte_en=0: rsp_valid in cycle 1 and no strobes.
- NUM_BANKS=3, req_bank=3. Required: rsp_valid+rsp_err in cycle 1, bank_sel never nonzero, rsp_rdata=0.
- Hold req_valid continuously for two reads. Required: second accept one cycle after the first rsp_valid; precharge and wl_en never overlap.
- Assert rst in cycle 3 of a write. Required: strobes 0 before the next edge, no rsp_valid, req_ready=1 after release.
